// File: rtl/classifier_head_pkg.sv
// Shared types and constants for the classifier output stage.
package classifier_head_pkg;

  // Unsigned fixed-point score in [0,1]; all-ones represents 1.0.
  localparam int Z2O_W = 16;
  typedef logic [Z2O_W-1:0] zero2one_t;

  localparam zero2one_t ZERO2ONE_ONE = '1;
  localparam int N_CLASS_DEFAULT = 43;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT
  } head_state_t;

endpackage

// File: rtl/classifier_head_if.sv
// Sample-in / result-out handshake bundle of the classifier head.
interface classifier_head_if
  import classifier_head_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEFAULT
);
  localparam int LBL_W = $clog2(N_CLASS);

  logic                    in_valid;
  logic                    in_ready;
  zero2one_t [N_CLASS-1:0] scores;
  logic [LBL_W-1:0]        label;
  logic                    learn_req;

  logic                    res_valid;
  logic                    res_ready;
  logic [LBL_W-1:0]        res_class;
  zero2one_t               res_score;
  logic                    res_correct;
  logic                    label_err;

  // Producer of samples and consumer of results.
  modport master (
    output in_valid, scores, label, learn_req, res_ready,
    input  in_ready, res_valid, res_class, res_score, res_correct, label_err
  );

  // The classifier head itself.
  modport slave (
    input  in_valid, scores, label, learn_req, res_ready,
    output in_ready, res_valid, res_class, res_score, res_correct, label_err
  );
endinterface

// File: rtl/classifier_head_argmax_seq.sv
// argmax_seq: one-compare-per-cycle argmax over a captured score vector.
// done is high during the cycle that performs the last compare; win_* are the
// best index/value including that cycle's compare.
module classifier_head_argmax_seq
  import classifier_head_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEFAULT,
  localparam int LBL_W = $clog2(N_CLASS)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  zero2one_t [N_CLASS-1:0] scores,
  output logic                    done,
  output logic [LBL_W-1:0]        win_idx,
  output zero2one_t               win_val
);

  zero2one_t [N_CLASS-1:0] scores_reg;
  logic [LBL_W-1:0]        idx_reg;
  logic [LBL_W-1:0]        best_idx_reg;
  zero2one_t               best_val_reg;
  logic                    busy_reg;
  logic                    take;

  // Strictly-greater replacement, so ties keep the lowest index.
  always_comb begin
    take    = 1'b0;
    done    = 1'b0;
    win_idx = best_idx_reg;
    win_val = best_val_reg;
    if (busy_reg) begin
      take = (scores_reg[idx_reg] > best_val_reg);
      done = (idx_reg == LBL_W'(N_CLASS - 1));
    end
    if (take) begin
      win_idx = idx_reg;
      win_val = scores_reg[idx_reg];
    end
  end

  // Seed with entry 0 on start, then walk idx over entries 1..N_CLASS-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scores_reg   <= '0;
      idx_reg      <= '0;
      best_idx_reg <= '0;
      best_val_reg <= '0;
      busy_reg     <= 1'b0;
    end else if (start) begin
      scores_reg   <= scores;
      idx_reg      <= LBL_W'(1);
      best_idx_reg <= '0;
      best_val_reg <= scores[0];
      busy_reg     <= 1'b1;
    end else if (busy_reg) begin
      best_idx_reg <= win_idx;
      best_val_reg <= win_val;
      if (done) begin
        busy_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + LBL_W'(1);
      end
    end
  end

endmodule

// File: rtl/classifier_head.sv
// classifier_head: argmax result stage behind the learning layer. Captures a
// score vector, scans it sequentially, reports the winner, keeps accuracy
// counters and drives the layer's target vector and learn strobe.
module classifier_head
  import classifier_head_pkg::*;
#(
  parameter int        N_CLASS   = N_CLASS_DEFAULT,
  parameter int        CNT_W     = 32,
  parameter zero2one_t TARGET_HI = ZERO2ONE_ONE,
  parameter zero2one_t TARGET_LO = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  classifier_head_if.slave        bus,
  input  logic                    clear_stats,
  output zero2one_t [N_CLASS-1:0] expected_out,
  output logic                    learn,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        correct_cnt
);

  localparam int LBL_W = $clog2(N_CLASS);

  head_state_t             state_reg, state_next;
  logic                    accept;
  logic                    scan_done;
  logic [LBL_W-1:0]        win_idx;
  zero2one_t               win_val;
  logic [LBL_W-1:0]        label_reg;
  logic                    learn_req_reg;
  logic                    label_ok;
  logic                    win_correct;
  logic [LBL_W-1:0]        res_class_reg;
  zero2one_t               res_score_reg;
  logic                    res_correct_reg;
  logic                    label_err_reg;
  logic                    learn_reg;
  logic [CNT_W-1:0]        total_reg;
  logic [CNT_W-1:0]        correct_reg;
  zero2one_t [N_CLASS-1:0] expected_reg;

  assign accept      = bus.in_valid && (state_reg == IDLE);
  assign label_ok    = (int'(label_reg) < N_CLASS);
  assign win_correct = label_ok && (label_reg == win_idx);

  classifier_head_argmax_seq #(.N_CLASS(N_CLASS)) u_argmax_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept),
    .scores  (bus.scores),
    .done    (scan_done),
    .win_idx (win_idx),
    .win_val (win_val)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: accept -> scan -> hold result until taken.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept)        state_next = SCAN;
      SCAN:    if (scan_done)     state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.res_valid = (state_reg == RESULT);
  end

  // Capture sample side-band on accept; latch the result when the scan ends.
  // learn is cleared on every other edge so it never outlasts one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      label_reg       <= '0;
      learn_req_reg   <= 1'b0;
      res_class_reg   <= '0;
      res_score_reg   <= '0;
      res_correct_reg <= 1'b0;
      label_err_reg   <= 1'b0;
      learn_reg       <= 1'b0;
    end else begin
      learn_reg <= 1'b0;
      if (accept) begin
        label_reg     <= bus.label;
        learn_req_reg <= bus.learn_req;
      end
      if (scan_done) begin
        res_class_reg   <= win_idx;
        res_score_reg   <= win_val;
        res_correct_reg <= win_correct;
        label_err_reg   <= !label_ok;
        learn_reg       <= learn_req_reg && label_ok;
      end
    end
  end

  // Saturating statistics; a clear beats a coincident increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_reg   <= '0;
      correct_reg <= '0;
    end else if (clear_stats) begin
      total_reg   <= '0;
      correct_reg <= '0;
    end else if (scan_done) begin
      if (total_reg != '1) total_reg <= total_reg + CNT_W'(1);
      if (win_correct && (correct_reg != '1)) correct_reg <= correct_reg + CNT_W'(1);
    end
  end

  // One-hot target per class; an out-of-range label leaves every entry low.
  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_target
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        expected_reg[gi] <= '0;
      end else if (scan_done) begin
        expected_reg[gi] <= (label_ok && (int'(label_reg) == gi)) ? TARGET_HI : TARGET_LO;
      end
    end
  end

  assign bus.res_class   = res_class_reg;
  assign bus.res_score   = res_score_reg;
  assign bus.res_correct = res_correct_reg;
  assign bus.label_err   = label_err_reg;
  assign expected_out    = expected_reg;
  assign learn           = learn_reg;
  assign total_cnt       = total_reg;
  assign correct_cnt     = correct_reg;

endmodule

// File: tb/tb_classifier_head.sv
// Directed plus randomized bench for classifier_head with a behavioural model.
module tb_classifier_head;
  import classifier_head_pkg::*;

  localparam int N  = 43;
  localparam int CW = 32;
  localparam int LW = $clog2(N);

  typedef zero2one_t [N-1:0] vec_t;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear_stats = 1'b0;
  vec_t           expected_out;
  logic           learn;
  logic [CW-1:0]  total_cnt;
  logic [CW-1:0]  correct_cnt;

  classifier_head_if #(.N_CLASS(N)) bus ();

  classifier_head #(.N_CLASS(N), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .clear_stats  (clear_stats),
    .expected_out (expected_out),
    .learn        (learn),
    .total_cnt    (total_cnt),
    .correct_cnt  (correct_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int total_m = 0;
  int correct_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the maximum score.
  function automatic int argmax_of(input vec_t v);
    int best = 0;
    for (int i = 1; i < N; i++) if (v[i] > v[best]) best = i;
    return best;
  endfunction

  // Reference: 1.0 at the label position, 0.0 elsewhere (all 0.0 if out of range).
  function automatic vec_t target_of(input int lbl);
    vec_t t;
    for (int i = 0; i < N; i++) t[i] = (i == lbl) ? 16'hFFFF : 16'h0000;
    return t;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = zero2one_t'($urandom);
    return v;
  endfunction

  // Offer one sample, follow it through scan and result, check everything.
  task automatic run_sample(input vec_t v, input int lbl, input bit lreq,
                            input int hold, input bit clr);
    int  exp_cls, lat, learn_cnt, busy_bad, unstable;
    bit  ok, exp_learn;
    exp_cls   = argmax_of(v);
    ok        = (lbl < N);
    exp_learn = lreq && ok;

    @(negedge clock);
    bus.scores    = v;
    bus.label     = LW'(lbl);
    bus.learn_req = lreq;
    bus.in_valid  = 1'b1;
    bus.res_ready = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.scores   = rand_vec();
    bus.label    = LW'($urandom);
    check("accept_in_ready", bus.in_ready, 0);

    lat = 0; learn_cnt = 0; busy_bad = 0; unstable = 0;
    while (!bus.res_valid && lat < 200) begin
      if (clr && lat == N - 2) clear_stats = 1'b1;
      @(posedge clock);
      @(negedge clock);
      clear_stats = 1'b0;
      lat++;
      if (learn && !bus.res_valid) learn_cnt++;
      if (bus.in_ready) busy_bad++;
    end
    check("latency", lat, N - 1);

    if (clr) begin
      total_m = 0; correct_m = 0;
    end else begin
      total_m++;
      if (ok && exp_cls == lbl) correct_m++;
    end

    check("res_class", bus.res_class, exp_cls);
    check("res_score", bus.res_score, v[exp_cls]);
    check("res_correct", bus.res_correct, ok && (exp_cls == lbl));
    check("label_err", bus.label_err, !ok);
    check_vec("expected_out", expected_out, target_of(lbl));
    check("learn_first", learn, exp_learn);
    check("total_cnt", total_cnt, total_m);
    check("correct_cnt", correct_cnt, correct_m);
    if (learn) learn_cnt++;

    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      @(negedge clock);
      if (learn) learn_cnt++;
      if (bus.in_ready) busy_bad++;
      if (!bus.res_valid || bus.res_class != LW'(exp_cls) || bus.res_score != v[exp_cls])
        unstable++;
    end
    check("hold_stable", unstable, 0);
    check("hold_total", total_cnt, total_m);

    bus.res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (learn) learn_cnt++;
    check("release_valid", bus.res_valid, 0);
    check("release_ready", bus.in_ready, 1);
    check("learn_pulses", learn_cnt, exp_learn);
    check("busy_in_ready", busy_bad, 0);
    $display("sample lbl=%0d cls=%0d hold=%0d learn=%0d total=%0d correct=%0d",
             lbl, exp_cls, hold, exp_learn, total_m, correct_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_learn"}, learn, 0);
    check({tag, "_res_class"}, bus.res_class, 0);
    check({tag, "_res_score"}, bus.res_score, 0);
    check({tag, "_res_correct"}, bus.res_correct, 0);
    check({tag, "_label_err"}, bus.label_err, 0);
    check({tag, "_total"}, total_cnt, 0);
    check({tag, "_correct"}, correct_cnt, 0);
    check_vec({tag, "_expected_out"}, expected_out, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lbl, sel, res_seen;

    bus.in_valid  = 1'b0;
    bus.scores    = '0;
    bus.label     = '0;
    bus.learn_req = 1'b0;
    bus.res_ready = 1'b1;

    // Reset state, with a sample offered that must not be captured.
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_ready", bus.in_ready, 1);

    // Argmax with labelling and learning.
    for (int i = 0; i < N; i++) v[i] = 16'h1000;
    v[7] = 16'hF000;
    run_sample(v, 7, 1'b1, 0, 1'b0);

    // Tie keeps the lowest index.
    v = '0;
    v[3] = 16'h8000; v[40] = 16'h8000;
    run_sample(v, 40, 1'b1, 0, 1'b0);

    // Back-pressure for 10 cycles.
    run_sample(rand_vec(), 12, 1'b1, 10, 1'b0);

    // Bad label, then a valid label without a learn request.
    run_sample(rand_vec(), 50, 1'b1, 0, 1'b0);
    v = rand_vec();
    run_sample(v, argmax_of(v), 1'b0, 0, 1'b0);

    // Randomized samples.
    for (int k = 0; k < 8; k++) begin
      v   = rand_vec();
      sel = $urandom_range(0, 3);
      if (sel < 2)       lbl = argmax_of(v);
      else if (sel == 2) lbl = $urandom_range(0, N - 1);
      else               lbl = $urandom_range(0, (1 << LW) - 1);
      run_sample(v, lbl, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    // Clear coinciding with the completion edge.
    v = rand_vec();
    run_sample(v, argmax_of(v), 1'b1, 0, 1'b1);

    // Give the counters a nonzero value before the abort test.
    v = rand_vec();
    run_sample(v, argmax_of(v), 1'b1, 0, 1'b0);

    // Reset in the middle of a scan.
    @(negedge clock);
    bus.scores    = rand_vec();
    bus.label     = LW'(5);
    bus.learn_req = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    total_m = 0; correct_m = 0;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    res_seen = 0;
    for (int c = 0; c < N + 10; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.res_valid || learn || !bus.in_ready) res_seen++;
    end
    check("abort_no_result", res_seen, 0);
    check("abort_total", total_cnt, 0);

    // Normal operation resumes.
    v = rand_vec();
    run_sample(v, argmax_of(v), 1'b1, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
